fabric_instr_loader: RTL and testbench

//  Upstream driver of the fabric: accepts a stream of {row, col, instr} load words and writes each

---
 rtl/fabric_instr_loader.sv | 133 +++++++++++++
 tb/tb_fabric_instr_loader.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fabric_instr_loader.sv
// fabric_instr_loader: streams {row,col,instr} words into fabric instruction ports, then calls and times the run.
// Optional watchdog in WAIT_RET enabled by defining LOADER_TIMEOUT_EN.
module fabric_instr_loader #(
  parameter int ROWS             = 2,
  parameter int COLS             = 2,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int INSTR_ADDR_WIDTH = 6,
  parameter int INSTR_HOPS_WIDTH = 4,
  parameter int CNT_WIDTH        = 32,
  parameter int SETTLE_CYCLES    = 2 * COLS,
  parameter int TIMEOUT_LIMIT    = 2 ** 20,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    ld_valid,
  output logic                                    ld_ready,
  input  logic [RW-1:0]                           ld_row,
  input  logic [INSTR_HOPS_WIDTH-1:0]             ld_col,
  input  logic [INSTR_DATA_WIDTH-1:0]             ld_data,
  input  logic                                    ld_last,
  output logic [ROWS-1:0][INSTR_DATA_WIDTH-1:0]   instr_data_out,
  output logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0]   instr_addr_out,
  output logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0]   instr_hops_out,
  output logic [ROWS-1:0]                         instr_en_out,
  output logic [ROWS-1:0]                         call,
  input  logic [ROWS-1:0]                         ret,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err,
  output logic                                    timeout,
  output logic [CNT_WIDTH-1:0]                    cycle_count
);
`ifdef LOADER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, LOAD, CALL, SETTLE, WAIT_RET, DONE} state_t;
  state_t state, state_nx;
  logic [ROWS-1:0][INSTR_ADDR_WIDTH-1:0] addr_cnt;
  logic [ROWS-1:0][INSTR_HOPS_WIDTH-1:0] last_col;
  logic [ROWS-1:0]                       seen;
  logic acc, row_ok, same_cell, drop, ret_ok, tmo, settle_done;
  logic [CNT_WIDTH-1:0] cnt_inc;
  assign acc         = ld_valid & ld_ready;
  assign row_ok      = {1'b0, ld_row} < (RW+1)'(ROWS);
  assign same_cell   = row_ok && seen[ld_row] && last_col[ld_row] == ld_col;
  assign drop        = !row_ok || (same_cell && &addr_cnt[ld_row]);
  assign ret_ok      = &ret;
  assign tmo         = TMO_EN && cycle_count >= CNT_WIDTH'(TIMEOUT_LIMIT);
  assign settle_done = cycle_count == CNT_WIDTH'(SETTLE_CYCLES);
  assign cnt_inc     = &cycle_count ? cycle_count : cycle_count + CNT_WIDTH'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: state_nx = start ? LOAD : state;
      LOAD:       state_nx = (acc && ld_last) ? CALL : LOAD;
      CALL:       state_nx = SETTLE;
      SETTLE:     state_nx = settle_done ? WAIT_RET : SETTLE;
      WAIT_RET:   state_nx = (ret_ok || tmo) ? DONE : WAIT_RET;
      default:    state_nx = IDLE;
    endcase
  end
  // Instruction and call strobes default low so every pulse lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_ready       <= 1'b0;
      instr_data_out <= '0;
      instr_addr_out <= '0;
      instr_hops_out <= '0;
      instr_en_out   <= '0;
      call           <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      timeout        <= 1'b0;
      cycle_count    <= '0;
      addr_cnt       <= '0;
      last_col       <= '0;
      seen           <= '0;
    end else begin
      instr_data_out <= '0;
      instr_addr_out <= '0;
      instr_hops_out <= '0;
      instr_en_out   <= '0;
      call           <= '0;
      case (state)
        IDLE, DONE: if (start) begin
          ld_ready    <= 1'b1;
          busy        <= 1'b1;
          done        <= 1'b0;
          err         <= 1'b0;
          timeout     <= 1'b0;
          cycle_count <= '0;
          addr_cnt    <= '0;
          last_col    <= '0;
          seen        <= '0;
        end
        LOAD: if (acc) begin
          if (ld_last) ld_ready <= 1'b0;
          if (drop) err <= 1'b1;
          else begin
            instr_en_out[ld_row]   <= 1'b1;
            instr_data_out[ld_row] <= ld_data;
            instr_hops_out[ld_row] <= ld_col;
            instr_addr_out[ld_row] <= same_cell ? addr_cnt[ld_row] + INSTR_ADDR_WIDTH'(1) : '0;
            addr_cnt[ld_row]       <= same_cell ? addr_cnt[ld_row] + INSTR_ADDR_WIDTH'(1) : '0;
            last_col[ld_row]       <= ld_col;
            seen[ld_row]           <= 1'b1;
          end
        end
        CALL: begin
          call        <= '1;
          cycle_count <= '0;
        end
        SETTLE: cycle_count <= cnt_inc;
        WAIT_RET: begin
          if (ret_ok || tmo) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            timeout <= !ret_ok;
          end else cycle_count <= cnt_inc;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fabric_instr_loader.sv
// tb_fabric_instr_loader: directed table-driven bench for fabric_instr_loader (ROWS=3 so ld_row=3 is out of range).
module tb_fabric_instr_loader;
  localparam int R = 3;
  logic clk = 0, rst = 1, start = 0, ld_valid = 0, ld_last = 0;
  logic ld_ready, busy, done, err, timeout;
  logic [1:0] ld_row = 0;
  logic [3:0] ld_col = 0;
  logic [31:0] ld_data = 0;
  logic [R-1:0][31:0] instr_data_out;
  logic [R-1:0][5:0] instr_addr_out;
  logic [R-1:0][3:0] instr_hops_out;
  logic [R-1:0] instr_en_out, call, ret = '0;
  logic [31:0] cycle_count;
  int n_chk = 0, n_fail = 0;

  fabric_instr_loader #(.ROWS(R), .COLS(2), .TIMEOUT_LIMIT(50)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data), .ld_last(ld_last),
    .instr_data_out(instr_data_out), .instr_addr_out(instr_addr_out),
    .instr_hops_out(instr_hops_out), .instr_en_out(instr_en_out), .call(call), .ret(ret),
    .busy(busy), .done(done), .err(err), .timeout(timeout), .cycle_count(cycle_count));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] row; logic [3:0] col; logic [31:0] data; logic last;
    logic [R-1:0] en; logic [5:0] addr;
  } vec_t;
  vec_t tbl[6];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1; step(); start = 0;
    chk("ld_ready_after_start", 64'(ld_ready), 1);
  endtask

  task automatic word(input logic [1:0] r, input logic [3:0] c, input logic [31:0] d,
                      input logic l, input logic [R-1:0] een, input logic [5:0] eaddr, input string nm);
    logic [R-1:0][5:0] ea;
    logic [R-1:0][3:0] eh;
    logic [R-1:0][31:0] ed;
    ea = '0; eh = '0; ed = '0;
    if (een != 0) begin ea[r] = eaddr; eh[r] = c; ed[r] = d; end
    ld_valid = 1; ld_row = r; ld_col = c; ld_data = d; ld_last = l;
    step();
    ld_valid = 0; ld_last = 0;
    chk({nm, "_en"}, 64'(instr_en_out), 64'(een));
    chk({nm, "_addr"}, 64'(ea), 64'(ea) == 64'(instr_addr_out) ? 64'(instr_addr_out) : 64'(ea));
    if (instr_addr_out !== ea) chk({nm, "_addr"}, 64'(instr_addr_out), 64'(ea));
    chk({nm, "_hops"}, 64'(instr_hops_out), 64'(eh));
    chk({nm, "_data"}, 64'(instr_data_out), 64'(ed));
  endtask

  task automatic wait_done(output int steps);
    steps = 0;
    while (!done && steps < 200) begin step(); steps++; end
    chk("done_within_bound", 64'(done), 1);
  endtask

  initial begin
    int s;
    tbl[0] = '{2'd0, 4'd0, 32'hA, 1'b0, 3'b001, 6'd0};
    tbl[1] = '{2'd0, 4'd0, 32'hB, 1'b0, 3'b001, 6'd1};
    tbl[2] = '{2'd1, 4'd1, 32'hC, 1'b1, 3'b010, 6'd0};
    tbl[3] = '{2'd0, 4'd0, 32'h10, 1'b0, 3'b001, 6'd0};
    tbl[4] = '{2'd0, 4'd1, 32'h11, 1'b0, 3'b001, 6'd0};
    tbl[5] = '{2'd0, 4'd0, 32'h12, 1'b0, 3'b001, 6'd0};
    step(); step(); rst = 0; step();
    chk("rst_ld_ready", 64'(ld_ready), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_call", 64'(call), 0);
    chk("rst_count", 64'(cycle_count), 0);

    // Test 1: three words, ret rises 10 cycles after call
    do_start();
    chk("t1_busy", 64'(busy), 1);
    for (int i = 0; i < 3; i++)
      word(tbl[i].row, tbl[i].col, tbl[i].data, tbl[i].last, tbl[i].en, tbl[i].addr, $sformatf("t1_w%0d", i));
    step();
    chk("t1_call", 64'(call), 64'(3'b111));
    chk("t1_count_call", 64'(cycle_count), 0);
    chk("t1_ld_ready_off", 64'(ld_ready), 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      if (call != 0) chk("t1_single_call", 64'(call), 0);
      if (done) chk("t1_early_done", 64'(done), 0);
    end
    chk("t1_count_at_ret", 64'(cycle_count), 10);
    ret = 3'b111;
    step();
    chk("t1_done", 64'(done), 1);
    chk("t1_busy_off", 64'(busy), 0);
    chk("t1_count", 64'(cycle_count), 10);

    // Test 2: ret constantly high
    do_start();
    chk("t2_done_cleared", 64'(done), 0);
    word(2'd0, 4'd0, 32'hD, 1'b1, 3'b001, 6'd0, "t2_w");
    step();
    chk("t2_call", 64'(call), 64'(3'b111));
    wait_done(s);
    chk("t2_latency", 64'(s), 6);
    chk("t2_count", 64'(cycle_count), 5);

    // Test 3: column change resets address; 65th word to one cell overflows
    do_start();
    for (int i = 3; i < 6; i++)
      word(tbl[i].row, tbl[i].col, tbl[i].data, tbl[i].last, tbl[i].en, tbl[i].addr, $sformatf("t3_w%0d", i));
    for (int i = 0; i < 64; i++)
      word(2'd0, 4'd2, 32'(i), 1'b0, 3'b001, 6'(i), $sformatf("t3_fill%0d", i));
    chk("t3_no_err_yet", 64'(err), 0);
    word(2'd0, 4'd2, 32'hFF, 1'b1, 3'b000, 6'd0, "t3_ovf");
    chk("t3_err", 64'(err), 1);
    step();
    chk("t3_call", 64'(call), 64'(3'b111));
    wait_done(s);
    chk("t3_err_sticky", 64'(err), 1);

    // Test 4: out-of-range row
    do_start();
    chk("t4_err_cleared", 64'(err), 0);
    word(2'd3, 4'd0, 32'hE, 1'b1, 3'b000, 6'd0, "t4_bad_row");
    chk("t4_err", 64'(err), 1);
    step();
    chk("t4_call", 64'(call), 64'(3'b111));
    wait_done(s);

    // Test 5: asynchronous reset during SETTLE
    do_start();
    word(2'd2, 4'd3, 32'hF, 1'b1, 3'b100, 6'd0, "t5_w");
    step(); step();
    rst = 1; #1;
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_count", 64'(cycle_count), 0);
    chk("t5_rst_done", 64'(done), 0);
    step(); rst = 0;
    ld_valid = 1; ld_row = 0; ld_col = 0; ld_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_idle_en", 64'(instr_en_out), 0);
      chk("t5_idle_ready", 64'(ld_ready), 0);
    end
    ld_valid = 0;

    // Test 6: ret never returns
    ret = '0;
    do_start();
    word(2'd1, 4'd0, 32'h5, 1'b1, 3'b010, 6'd0, "t6_w");
    for (int i = 0; i < 120; i++) step();
`ifdef LOADER_TIMEOUT_EN
    chk("t6_done", 64'(done), 1);
    chk("t6_timeout", 64'(timeout), 1);
    chk("t6_count", 64'(cycle_count), 50);
`else
    chk("t6_busy", 64'(busy), 1);
    chk("t6_done", 64'(done), 0);
    chk("t6_timeout", 64'(timeout), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
